signed_2s_comp_sub: RTL and testbench

- Multi-cycle signed two's-complement subtractor. Computes s_sub = num1 - num2 as num1 + ~num2 + 1.
- Processes one CHUNK-bit slice per clock, least significant slice first, with a registered carry chain between slices.
- Sits beside the combinational signed adder in the arithmetic datapath. Used where a narrow, timing-friendly subtract is wanted.
- Valid/ready on both input and output. Reports overflow, negative and zero flags alongside the result.

---
 rtl/signed_2s_comp_sub_if.sv | 31 +++
 rtl/signed_2s_comp_sub.sv | 117 +++++++++++
 tb/tb_signed_2s_comp_sub.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/signed_2s_comp_sub_if.sv
`default_nettype none
// ============================================================================
// Module      : signed_2s_comp_sub_if
// Description : Valid/ready operand and result bundle for signed_2s_comp_sub.
// Revision    : 1.0 - initial release
// ============================================================================
interface signed_2s_comp_sub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s_sub;
    logic             overflow;
    logic             negative;
    logic             zero;

    modport master (
        output in_valid, num1, num2, out_ready,
        input  in_ready, out_valid, s_sub, overflow, negative, zero
    );

    modport slave (
        input  in_valid, num1, num2, out_ready,
        output in_ready, out_valid, s_sub, overflow, negative, zero
    );
endinterface
`default_nettype wire

// File: rtl/signed_2s_comp_sub.sv
`default_nettype none
// ============================================================================
// Module      : signed_2s_comp_sub
// Description : Serial signed subtractor, num1 + ~num2 + 1, one CHUNK slice
//               per clock, LSB slice first, with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_2s_comp_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    signed_2s_comp_sub_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_nb;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_s_sub;
    logic             r_overflow;
    logic             r_negative;
    logic             r_zero;

    int               w_base;
    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_overflow;

    always_comb begin
        w_base     = int'(r_idx) * CHUNK;
        w_sum      = {1'b0, r_a[w_base +: CHUNK]} + {1'b0, r_nb[w_base +: CHUNK]}
                   + {{CHUNK{1'b0}}, r_carry};
        w_acc_next = r_acc;
        w_acc_next[w_base +: CHUNK] = w_sum[CHUNK-1:0];
        // r_nb holds ~num2, so equal MSBs here mean the operand signs differ
        w_overflow = (r_a[WIDTH-1] == r_nb[WIDTH-1])
                   && (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_a         <= '0;
            r_nb        <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_s_sub     <= '0;
            r_overflow  <= 1'b0;
            r_negative  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.num1;
                        r_nb       <= ~bus.num2;
                        r_acc      <= '0;
                        r_carry    <= 1'b1;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= c_st_calc;
                    end
                end
                c_st_calc: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_sum[CHUNK];
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == c_last_idx) begin
                        r_s_sub     <= w_acc_next;
                        r_overflow  <= w_overflow;
                        r_negative  <= w_acc_next[WIDTH-1];
                        r_zero      <= (w_acc_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.s_sub     = r_s_sub;
    assign bus.overflow  = r_overflow;
    assign bus.negative  = r_negative;
    assign bus.zero      = r_zero;
endmodule
`default_nettype wire

// File: tb/tb_signed_2s_comp_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_2s_comp_sub
// Description : Self-checking bench for signed_2s_comp_sub, directed corner
//               cases plus randomized operands against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_2s_comp_sub;
    localparam int W = 32;
    localparam int C = 8;
    localparam int N = W / C;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    signed_2s_comp_sub_if #(.WIDTH(W)) bus ();

    signed_2s_comp_sub #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular difference, overflow from the exact integer result
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] es;
        longint       d;
        longint       lim;
        logic         eo;
        int           lat;
        es  = a - b;
        d   = longint'($signed(a)) - longint'($signed(b));
        lim = longint'(1) << (W - 1);
        eo  = (d >= lim) || (d < -lim);

        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.num1      = a;
        bus.num2      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            check("in_ready_busy", 64'(bus.in_ready), 64'd0);
            bus.num1 = $urandom;
            bus.num2 = $urandom;
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(N));
        check("s_sub", 64'(bus.s_sub), 64'(es));
        check("overflow", 64'(bus.overflow), 64'(eo));
        check("negative", 64'(bus.negative), 64'(es[W-1]));
        check("zero", 64'(bus.zero), 64'(es == '0));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.num1     = $urandom;
            bus.num2     = $urandom;
            @(negedge clk);
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_s_sub", 64'(bus.s_sub), 64'(es));
            check("bp_flags", 64'({bus.overflow, bus.negative, bus.zero}),
                  64'({eo, es[W-1], es == '0}));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_valid", 64'(bus.out_valid), 64'd0);
        check("post_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.num1      = '0;
        bus.num2      = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_s_sub", 64'(bus.s_sub), 64'd0);
        check("rst_flags", 64'({bus.overflow, bus.negative, bus.zero}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(32'd5, 32'd3, 0);
        do_op(32'hFFFF_FFFB, 32'd3, 0);
        do_op(32'd3, 32'hFFFF_FFFB, 0);
        do_op(32'h8000_0000, 32'd1, 0);
        do_op(32'h8000_0000, 32'h8000_0000, 0);
        do_op(32'd100, 32'd1, 10);
        do_op(32'd100, 32'd1, 0);
        do_op(32'd0, 32'd1, 0);
        do_op(32'h0000_00FF, 32'h0000_00FF, 1);
        do_op(32'h0001_0000, 32'd1, 0);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);

        // Abort at compute edge E2, after a result with nonzero value and flags
        bus.num1     = 32'd1234;
        bus.num2     = 32'd1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_s_sub", 64'(bus.s_sub), 64'd0);
        check("abort_flags", 64'({bus.overflow, bus.negative, bus.zero}), 64'd0);
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            check("abort_no_valid", 64'(bus.out_valid), 64'd0);
        end
        do_op(32'd7, 32'd7, 0);

        for (int k = 0; k < 150; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: ra = {1'b1, 31'($urandom_range(0, 3))};
                2: rb = {1'b1, 31'($urandom)};
                default: ;
            endcase
            do_op(ra, rb, $urandom_range(0, 2) == 0 ? $urandom_range(1, 4) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
